// File: rtl/main_control_fsm_pkg.sv
// Shared encodings for the multi-cycle main control unit: state codes, opcodes,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_R_WB     = 4'd4;
    localparam logic [3:0] S_EXEC_I   = 4'd5;
    localparam logic [3:0] S_I_WB     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_MEM_WB   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_HALT     = 4'd13;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_J     = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_FUNC = 3'b011;
    localparam logic [2:0] ALUOP_AND  = 3'b110;
    localparam logic [2:0] ALUOP_OR   = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_ONE    = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_BRANCH = 2'b11;

    // States that wait on the memory ready handshake and are watched by the timer.
    function automatic logic is_mem_state(input logic [3:0] state);
        return (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    endfunction

endpackage

// File: rtl/main_control_fsm_mem_wait_timer.sv
// Memory watchdog: counts stalled cycles of one access and pulses timeout on
// the stalled cycle that brings the count to MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic timeout
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable && !ready) begin
            count <= count + 1'b1;
        end
    end

    // The current stalled cycle is the MEM_TIMEOUT-th one; a ready in this cycle wins.
    assign timeout = enable && !ready && (count == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM for the 16-bit processor: sequences each
// instruction and drives all datapath selects, write enables and alu_op.
module main_control_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       err_timeout
);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [2:0] i_alu_op;
    logic       timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (next_state != state),
        .enable  (is_mem_state(state)),
        .ready   (mem_ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_RESET;
            err_timeout <= 1'b0;
            i_alu_op    <= ALUOP_ADD;
        end else begin
            state <= next_state;
            if (timeout) begin
                err_timeout <= 1'b1;
            end
            // I-type ALU operation is captured at decode so EXEC_I never reads opcode.
            if (state == S_DECODE) begin
                case (opcode)
                    OP_ANDI: i_alu_op <= ALUOP_AND;
                    OP_ORI:  i_alu_op <= ALUOP_OR;
                    default: i_alu_op <= ALUOP_ADD;
                endcase
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_HALT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                 next_state = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI: next_state = S_EXEC_I;
                    OP_LW, OP_SW:             next_state = S_MEM_ADDR;
                    OP_BEQ:                   next_state = S_BRANCH;
                    OP_J:                     next_state = S_JUMP;
                    OP_HALT:                  next_state = S_HALT;
                    default:                  next_state = S_FETCH;
                endcase
            end
            S_EXEC_R: next_state = S_R_WB;
            S_R_WB:   next_state = S_FETCH;
            S_EXEC_I: next_state = S_I_WB;
            S_I_WB:   next_state = S_FETCH;
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      next_state = S_MEM_RD;
                else if (opcode == OP_SW) next_state = S_MEM_WR;
                else                      next_state = S_FETCH;
            end
            S_MEM_RD: begin
                if (mem_ready)    next_state = S_MEM_WB;
                else if (timeout) next_state = S_HALT;
            end
            S_MEM_WB: next_state = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)    next_state = S_FETCH;
                else if (timeout) next_state = S_HALT;
            end
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_RESET;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        alu_op        = ALUOP_ADD;
        halted        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_ONE;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = ALUB_BRANCH;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNC;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = i_alu_op;
            end
            S_I_WB: reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: a per-cycle vector table plus
// hand-built sequences for watchdog, ready-at-limit and mid-instruction reset.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, halted, err_timeout;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_control_fsm #(
        .MEM_TIMEOUT (15),
        .CNT_W       (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .halted        (halted),
        .err_timeout   (err_timeout)
    );

    // Field order: pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
    // ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, halted, err_timeout
    logic [18:0] act;
    assign act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                  alu_op, halted, err_timeout};

    localparam logic [18:0] E_IDLE       = '0;
    localparam logic [18:0] E_FETCH_RDY  = {1'b1,1'b0,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,1'b0,1'b0};
    localparam logic [18:0] E_FETCH_WAIT = {1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,1'b0,1'b0};
    localparam logic [18:0] E_DECODE     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,1'b0,1'b0};
    localparam logic [18:0] E_EXEC_R     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b011,1'b0,1'b0};
    localparam logic [18:0] E_R_WB       = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,1'b0,1'b0};
    localparam logic [18:0] E_EXEC_ADD   = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,1'b0,1'b0};
    localparam logic [18:0] E_EXEC_AND   = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b110,1'b0,1'b0};
    localparam logic [18:0] E_EXEC_OR    = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b111,1'b0,1'b0};
    localparam logic [18:0] E_I_WB       = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,1'b0,1'b0};
    localparam logic [18:0] E_MEM_RD     = {1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0,1'b0};
    localparam logic [18:0] E_MEM_WB     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,1'b0,1'b0};
    localparam logic [18:0] E_MEM_WR     = {1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0,1'b0};
    localparam logic [18:0] E_BRANCH     = {1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,1'b0,1'b0};
    localparam logic [18:0] E_JUMP       = {1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0,1'b0};
    localparam logic [18:0] E_HALT       = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b1,1'b0};
    localparam logic [18:0] E_HALT_ERR   = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b1,1'b1};

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        z;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] o, input logic z,
                                input logic rdy, input logic [18:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.z = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Inputs change mid-low-phase; outputs are compared 1 ns later, before the next rising edge.
    task automatic step(input logic r, input logic [3:0] o, input logic z, input logic rdy,
                        input logic [18:0] e, input string nm);
        @(negedge clk);
        reset_n   = r;
        opcode    = o;
        zero      = z;
        mem_ready = rdy;
        #1;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", nm, act, e);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 4'h0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 3; i++) add(0, 4'h0, 0, 1, E_IDLE);
        add(1, 4'h0, 0, 1, E_IDLE);
        // R-type: reg_write with reg_dst in the fourth cycle from fetch
        add(1, 4'h0, 0, 1, E_FETCH_RDY); add(1, 4'h0, 0, 1, E_DECODE);
        add(1, 4'h0, 1, 1, E_EXEC_R);    add(1, 4'h0, 0, 1, E_R_WB);
        add(1, 4'h1, 0, 1, E_FETCH_RDY); add(1, 4'h1, 0, 1, E_DECODE);
        add(1, 4'h1, 0, 1, E_EXEC_ADD);  add(1, 4'h1, 0, 1, E_I_WB);
        // ANDI with opcode scrambled after decode: the op must come from decode time
        add(1, 4'h2, 0, 1, E_FETCH_RDY); add(1, 4'h2, 0, 1, E_DECODE);
        add(1, 4'h9, 0, 1, E_EXEC_AND);  add(1, 4'h9, 0, 1, E_I_WB);
        add(1, 4'h3, 0, 1, E_FETCH_RDY); add(1, 4'h3, 0, 1, E_DECODE);
        add(1, 4'h3, 0, 1, E_EXEC_OR);   add(1, 4'h3, 0, 1, E_I_WB);
        // LW with two wait cycles: 7 cycles total
        add(1, 4'h4, 0, 1, E_FETCH_RDY); add(1, 4'h4, 0, 1, E_DECODE);
        add(1, 4'h4, 0, 1, E_EXEC_ADD);  add(1, 4'h4, 0, 0, E_MEM_RD);
        add(1, 4'h4, 0, 0, E_MEM_RD);    add(1, 4'h4, 0, 1, E_MEM_RD);
        add(1, 4'h4, 0, 1, E_MEM_WB);
        // SW with one fetch wait
        add(1, 4'h5, 0, 0, E_FETCH_WAIT); add(1, 4'h5, 0, 1, E_FETCH_RDY);
        add(1, 4'h5, 0, 1, E_DECODE);     add(1, 4'h5, 0, 1, E_EXEC_ADD);
        add(1, 4'h5, 0, 1, E_MEM_WR);
        add(1, 4'h6, 1, 1, E_FETCH_RDY); add(1, 4'h6, 1, 1, E_DECODE); add(1, 4'h6, 1, 1, E_BRANCH);
        add(1, 4'h6, 0, 1, E_FETCH_RDY); add(1, 4'h6, 0, 1, E_DECODE); add(1, 4'h6, 0, 1, E_BRANCH);
        add(1, 4'h7, 0, 1, E_FETCH_RDY); add(1, 4'h7, 0, 1, E_DECODE); add(1, 4'h7, 0, 1, E_JUMP);
        // Illegal opcode behaves as a NOP and returns to fetch
        add(1, 4'hA, 0, 1, E_FETCH_RDY); add(1, 4'hA, 0, 1, E_DECODE);
        add(1, 4'h7, 0, 1, E_FETCH_RDY); add(1, 4'h7, 0, 1, E_DECODE); add(1, 4'h7, 0, 1, E_JUMP);
        add(1, 4'hF, 0, 1, E_FETCH_RDY); add(1, 4'hF, 0, 1, E_DECODE);
        add(1, 4'hF, 0, 0, E_HALT); add(1, 4'h0, 0, 1, E_HALT); add(1, 4'h5, 1, 0, E_HALT);
        add(1, 4'h4, 0, 1, E_HALT);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].rdy, vecs[i].exp,
                 $sformatf("vec[%0d]", i));
        end

        // SW with memory stuck: 15 stalled cycles, then sticky halt + error until reset
        step(0, 4'h0, 0, 1, E_HALT, "halt_before_reset_edge");
        step(1, 4'h5, 0, 1, E_IDLE, "reset_state_after_halt");
        step(1, 4'h5, 0, 1, E_FETCH_RDY, "sw_to_fetch");
        step(1, 4'h5, 0, 1, E_DECODE, "sw_to_decode");
        step(1, 4'h5, 0, 1, E_EXEC_ADD, "sw_to_addr");
        for (int i = 0; i < 15; i++) step(1, 4'h5, 0, 0, E_MEM_WR, $sformatf("sw_stall[%0d]", i));
        step(1, 4'h5, 0, 0, E_HALT_ERR, "timeout_halt");
        step(1, 4'h0, 0, 1, E_HALT_ERR, "timeout_sticky_ready");
        step(0, 4'h0, 0, 1, E_HALT_ERR, "timeout_sticky_until_edge");
        step(1, 4'h4, 0, 1, E_IDLE, "timeout_cleared_by_reset");

        // Ready arriving on the last allowed cycle completes normally, in fetch and LW
        for (int i = 0; i < 14; i++) step(1, 4'h4, 0, 0, E_FETCH_WAIT, $sformatf("fetch_stall[%0d]", i));
        step(1, 4'h4, 0, 1, E_FETCH_RDY, "fetch_ready_at_limit");
        step(1, 4'h4, 0, 1, E_DECODE, "lw_limit_decode");
        step(1, 4'h4, 0, 1, E_EXEC_ADD, "lw_limit_addr");
        for (int i = 0; i < 14; i++) step(1, 4'h4, 0, 0, E_MEM_RD, $sformatf("lw_stall[%0d]", i));
        step(1, 4'h4, 0, 1, E_MEM_RD, "lw_ready_at_limit");
        step(1, 4'h4, 0, 1, E_MEM_WB, "lw_limit_writeback");

        // Reset in the middle of an R-type instruction
        step(1, 4'h0, 0, 1, E_FETCH_RDY, "mid_fetch");
        step(1, 4'h0, 0, 1, E_DECODE, "mid_decode");
        step(0, 4'h0, 0, 1, E_EXEC_R, "mid_exec_reset_driven");
        step(1, 4'h0, 0, 1, E_IDLE, "mid_reset_state");
        step(1, 4'h0, 0, 1, E_FETCH_RDY, "mid_refetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation_time_limit actual=expired required=finished");
        $fatal(1);
    end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multi-cycle main control unit for the 16-bit processor.
- Decodes the opcode in IR[15:12] and sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select, every write enable, and the 3-bit alu_op consumed by the ALU control decoder.
- Waits on the memory ready handshake; a watchdog timer halts the core on a stuck memory access.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready in any memory state before the core halts with an error.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- opcode  in  4  IR[15:12]
- zero  in  1  ALU zero flag, used for BEQ
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when zero=1
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 1, 10 = sign-extended immediate, 11 = sign-extended branch offset
- alu_op  out  3  000 ADD, 001 SUB, 011 FUNC (R-type, function field decides), 110 AND, 111 OR
- halted  out  1  core stopped
- err_timeout  out  1  sticky flag: memory watchdog fired

Behaviour:
- State register updates on the rising edge of clk. reset_n = 0 at any edge, including mid-instruction, loads S_RESET and clears the wait counter and err_timeout.
- S_RESET: all outputs 0. Next state is S_FETCH unconditionally.
- Outputs are Moore, decoded from the state. The exception is pc_write and ir_write in S_FETCH, which are qualified by mem_ready.
- Any output not listed for a state is 0.
- S_FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Stays in S_FETCH while mem_ready=0; goes to S_DECODE when mem_ready=1.
- S_DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target precompute).
  - Transitions by opcode: 0000 -> S_EXEC_R; 0001/0010/0011 -> S_EXEC_I; 0100/0101 -> S_MEM_ADDR; 0110 -> S_BRANCH; 0111 -> S_JUMP; 1111 -> S_HALT.
  - Any other opcode -> S_FETCH, executed as a NOP.
- S_EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=011. Next: S_R_WB.
- S_R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: S_FETCH.
- S_EXEC_I: alu_src_a=1, alu_src_b=10, alu_op = 000 (ADDI), 110 (ANDI), 111 (ORI). Next: S_I_WB.
- S_I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: S_FETCH.
- S_MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Next: S_MEM_RD for opcode 0100, S_MEM_WR for opcode 0101.
- S_MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then S_MEM_WB.
- S_MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: S_FETCH.
- S_MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then S_FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Next: S_FETCH.
- S_JUMP: pc_write=1, pc_source=10. Next: S_FETCH.
- S_HALT: halted=1, all other outputs 0. Absorbing; only reset exits.
- Zero-wait latency in cycles: R-type 4, I-type 4, LW 5, SW 4, BEQ 3, J 3. Each wait cycle in S_FETCH, S_MEM_RD or S_MEM_WR adds one.
- Wait counter:
  - Cleared on entry to any memory state.
  - Increments each cycle spent in that state with mem_ready=0.
  - If the count reaches MEM_TIMEOUT with mem_ready still 0: next state is S_HALT and err_timeout sets (sticky until reset).
  - mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT wins: the access completes normally and there is no timeout.
- The zero input is ignored in every state except S_BRANCH.
- opcode is sampled only in S_DECODE and S_MEM_ADDR.

Decomposition:
- Package ctrl_pkg holds:
  - state encoding constants (S_RESET .. S_HALT);
  - opcode constants OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT;
  - ALUOP_ADD / SUB / FUNC / AND / OR;
  - pc_source and alu_src_b select constants.
- One sub-module, mem_wait_timer: clear, enable and ready inputs; timeout pulse output.

Test Plan:
- Reset held low 3 cycles, then released with mem_ready=1 and opcode=0000 -> all outputs 0 during reset and the first cycle after release; ir_write=1 in the next cycle; reg_write=1 with reg_dst=1 exactly 4 cycles after fetch starts.
- LW (opcode 0100) with mem_ready=0 for 2 cycles in S_MEM_RD -> mem_read and i_or_d held high for 3 cycles; mem_to_reg=1 and reg_write=1 one cycle later; total 7 cycles.
- BEQ (opcode 0110) with zero=1, then with zero=0 -> both cases: pc_write_cond=1, alu_op=001, pc_source=01 in cycle 3, next state S_FETCH. PC update happens only via zero (datapath check).
- ANDI (0010) and ORI (0011) -> alu_op=110 and alu_op=111 respectively in S_EXEC_I; alu_src_b=10.
- mem_ready stuck at 0 in S_MEM_WR with MEM_TIMEOUT=15 -> after 15 wait cycles the FSM enters S_HALT, halted=1, err_timeout=1; both stay set until reset_n=0.
- Illegal opcode 1010 -> returns to S_FETCH after decode with no write enable asserted. Opcode 1111 -> halted=1 permanently, even when mem_ready toggles.
